// File: rtl/axis_line_tx.sv
// Video line transmitter: paces a beat source into an AXI-Stream frame with SOF/EOL markers,
// horizontal/vertical blanking, a frame-done pulse and a sticky underrun flag.
module axis_line_tx #(
    parameter int unsigned IMG_WIDTH  = 640,
    parameter int unsigned IMG_HEIGHT = 480,
    parameter int unsigned DATA_WIDTH = 96,
    parameter int unsigned H_BLANK    = 16,
    parameter int unsigned V_BLANK    = 64
) (
    input  logic                  I_clk,
    input  logic                  I_rst_n,
    input  logic                  I_enable,
    input  logic [DATA_WIDTH-1:0] I_sdata,
    input  logic                  I_svalid,
    output logic                  O_sready,
    output logic [DATA_WIDTH-1:0] O_tdata,
    output logic                  O_tvalid,
    input  logic                  I_tready,
    output logic                  O_tuser,
    output logic                  O_tlast,
    output logic                  O_frame_done,
    output logic                  O_underrun
);

    localparam int unsigned LINE_BEATS = IMG_WIDTH >> 2;
    localparam logic [12:0] LineBeats  = 13'(LINE_BEATS);
    localparam logic [12:0] LastBeat   = 13'(LINE_BEATS - 1);
    localparam logic [12:0] LastLine   = 13'(IMG_HEIGHT - 1);
    localparam logic [15:0] HbLoad     = 16'(H_BLANK - 1);
    localparam logic [15:0] VbLoad     = 16'(V_BLANK - 1);

    typedef enum logic [1:0] {
        StIdle,
        StActive,
        StHblank,
        StVblank
    } state_e;

    state_e      state_q, state_d;
    logic [12:0] x_cnt;
    logic [12:0] y_cnt;
    logic [15:0] blank_cnt;

    logic load;
    logic accept;
    logic line_end;
    logic frame_end;
    logic blank_tc;

    assign load      = O_sready && I_svalid;
    assign accept    = O_tvalid && I_tready;
    assign line_end  = (state_q == StActive) && accept && O_tlast;
    assign frame_end = line_end && (y_cnt == LastLine);
    assign blank_tc  = (blank_cnt == '0);

    always_comb begin
        state_d  = state_q;
        O_sready = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (I_enable) state_d = StActive;
            end
            StActive: begin
                O_sready = (x_cnt < LineBeats) && (!O_tvalid || I_tready);
                if (frame_end) begin
                    state_d = StVblank;
                end else if (line_end) begin
                    state_d = StHblank;
                end
            end
            StHblank: begin
                if (blank_tc) state_d = StActive;
            end
            StVblank: begin
                // Enable is only sampled here, so a frame in flight always completes.
                if (blank_tc) state_d = I_enable ? StActive : StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            x_cnt     <= '0;
            y_cnt     <= '0;
            blank_cnt <= '0;
        end else if (frame_end) begin
            x_cnt     <= '0;
            y_cnt     <= '0;
            blank_cnt <= VbLoad;
        end else if (line_end) begin
            x_cnt     <= '0;
            y_cnt     <= y_cnt + 13'd1;
            blank_cnt <= HbLoad;
        end else begin
            if (load) x_cnt <= x_cnt + 13'd1;
            if ((state_q == StHblank || state_q == StVblank) && !blank_tc) begin
                blank_cnt <= blank_cnt - 16'd1;
            end
        end
    end

    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            O_tdata  <= '0;
            O_tvalid <= 1'b0;
            O_tuser  <= 1'b0;
            O_tlast  <= 1'b0;
        end else if (load) begin
            O_tdata  <= I_sdata;
            O_tvalid <= 1'b1;
            O_tuser  <= (x_cnt == '0) && (y_cnt == '0);
            O_tlast  <= (x_cnt == LastBeat);
        end else if (accept) begin
            O_tvalid <= 1'b0;
            O_tuser  <= 1'b0;
            O_tlast  <= 1'b0;
        end
    end

    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            O_frame_done <= 1'b0;
            O_underrun   <= 1'b0;
        end else begin
            O_frame_done <= frame_end;
            // Starvation only counts mid-line; waiting for the first beat of a line is legal.
            if ((state_q == StActive) && (x_cnt != '0) && (x_cnt < LineBeats) &&
                O_sready && !I_svalid) begin
                O_underrun <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_axis_line_tx.sv
// Scoreboard bench for axis_line_tx: a source process predicts each beat's markers from its
// position in the frame, and a monitor pops and compares every accepted output beat.
module tb_axis_line_tx;

    localparam int unsigned IW = 16;
    localparam int unsigned IH = 2;
    localparam int unsigned DW = 96;
    localparam int unsigned HB = 3;
    localparam int unsigned VB = 5;
    localparam int unsigned LB = IW >> 2;
    localparam int unsigned FB = LB * IH;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          enable = 1'b0;
    logic [DW-1:0] sdata = '0;
    logic          svalid = 1'b0;
    logic          sready;
    logic [DW-1:0] tdata;
    logic          tvalid;
    logic          tready = 1'b1;
    logic          tuser;
    logic          tlast;
    logic          frame_done;
    logic          underrun;

    axis_line_tx #(
        .IMG_WIDTH (IW),
        .IMG_HEIGHT(IH),
        .DATA_WIDTH(DW),
        .H_BLANK   (HB),
        .V_BLANK   (VB)
    ) dut (
        .I_clk       (clk),
        .I_rst_n     (rst_n),
        .I_enable    (enable),
        .I_sdata     (sdata),
        .I_svalid    (svalid),
        .O_sready    (sready),
        .O_tdata     (tdata),
        .O_tvalid    (tvalid),
        .I_tready    (tready),
        .O_tuser     (tuser),
        .O_tlast     (tlast),
        .O_frame_done(frame_done),
        .O_underrun  (underrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] data;
        logic          user;
        logic          last;
        logic          eof;
    } beat_t;

    typedef struct {
        int   cyc;
        logic user;
        logic last;
    } log_t;

    beat_t exp_q[$];
    log_t  acc_log[$];
    int    fd_cyc[$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Source: beat k of a frame carries SOF when k==0 and EOL at the end of every line.
    int   k = 0;
    int   gap_at = -1;
    int   gap_left = 0;
    int   seq = 0;
    logic src_en = 1'b0;
    logic took;

    initial begin
        forever begin
            @(negedge clk);
            took = svalid && sready && rst_n;
            if (took) begin
                exp_q.push_back('{data: sdata, user: (k == 0), last: ((k % LB) == LB - 1),
                                  eof: (k == FB - 1)});
                if (k == gap_at) begin
                    gap_left = 2;
                    gap_at   = -1;
                end
                k = (k + 1) % FB;
            end
            @(posedge clk);
            #1;
            if (took) begin
                seq++;
                sdata = {$urandom(), $urandom(), 32'(seq)};
            end
            svalid = src_en && (gap_left == 0);
            if (gap_left > 0) gap_left--;
        end
    end

    // Monitor: compares accepted beats, held data under back-pressure and frame_done timing.
    logic          stall = 1'b0;
    logic [DW-1:0] stall_data = '0;
    logic          fd_pend = 1'b0;
    beat_t         b;

    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                stall   = 1'b0;
                fd_pend = 1'b0;
                continue;
            end
            chk("frame_done", frame_done, fd_pend);
            if (stall) begin
                chk("hold_valid", tvalid, 1);
                chk("hold_data", tdata, stall_data);
            end
            fd_pend = 1'b0;
            if (tvalid && !tready) chk("sready_stall", sready, 0);
            if (tvalid && tready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_beat: got %0h, required no beat (cycle %0d)",
                             tdata, cyc);
                end else begin
                    b = exp_q.pop_front();
                    chk("beat_data", tdata, b.data);
                    chk("beat_tuser", tuser, b.user);
                    chk("beat_tlast", tlast, b.last);
                    fd_pend = b.eof;
                    acc_log.push_back('{cyc: cyc, user: tuser, last: tlast});
                end
            end
            stall      = tvalid && !tready;
            stall_data = tdata;
            if (frame_done) fd_cyc.push_back(cyc);
        end
    end

    task automatic check_zero(input string name);
        chk({name, "_tdata"}, tdata, 0);
        chk({name, "_tvalid"}, tvalid, 0);
        chk({name, "_tuser"}, tuser, 0);
        chk({name, "_tlast"}, tlast, 0);
        chk({name, "_sready"}, sready, 0);
        chk({name, "_frame_done"}, frame_done, 0);
        chk({name, "_underrun"}, underrun, 0);
    endtask

    // Caller has already pulled rst_n low; clears the model and releases reset.
    task automatic finish_reset();
        enable = 1'b0;
        src_en = 1'b0;
        tready = 1'b1;
        repeat (2) @(posedge clk);
        exp_q.delete();
        acc_log.delete();
        fd_cyc.delete();
        k        = 0;
        gap_at   = -1;
        gap_left = 0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input string name);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_zero(name);
        finish_reset();
    endtask

    task automatic wait_log(input int n, input int limit, input string name);
        int c = 0;
        while (acc_log.size() < n && c < limit) begin
            @(posedge clk);
            c++;
        end
        #1;
        checks++;
        if (acc_log.size() < n) begin
            errors++;
            $display("FAIL %s: got %0d beats, required %0d within %0d cycles", name,
                     acc_log.size(), n, limit);
        end
    endtask

    task automatic wait_visible(input int n, input string name);
        int c = 0;
        do begin
            @(posedge clk);
            #1;
            c++;
        end while (!(tvalid && acc_log.size() == n) && c < 200);
        checks++;
        if (!(tvalid && acc_log.size() == n)) begin
            errors++;
            $display("FAIL %s: beat %0d never visible, got %0d accepted", name, n,
                     acc_log.size());
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1);
    end

    initial begin
        int nl;

        // Reset state and free-running frame timing.
        do_reset("reset");
        enable = 1'b1;
        src_en = 1'b1;
        wait_log(9, 300, "t1_beats");
        if (acc_log.size() >= 9) begin
            for (int i = 1; i < 4; i++) chk("t1_line_rate", acc_log[i].cyc - acc_log[i-1].cyc, 1);
            chk("t1_hgap", acc_log[4].cyc - acc_log[3].cyc, HB + 2);
            chk("t1_tlast7", acc_log[7].last, 1);
            chk("t1_fd_seen", fd_cyc.size() >= 1, 1);
            if (fd_cyc.size() >= 1) begin
                chk("t1_fd_time", fd_cyc[0] - acc_log[7].cyc, 1);
                chk("t1_vgap", acc_log[8].cyc - fd_cyc[0], VB + 1);
            end
            chk("t1_tuser8", acc_log[8].user, 1);
        end
        chk("t1_underrun", underrun, 0);

        // Back-pressure for 4 cycles on beat 2.
        do_reset("t2_reset");
        enable = 1'b1;
        src_en = 1'b1;
        wait_visible(2, "t2_beat2");
        tready = 1'b0;
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        tready = 1'b1;
        wait_log(16, 300, "t2_beats");
        if (acc_log.size() >= 3) chk("t2_stall_len", acc_log[2].cyc - acc_log[1].cyc, 5);
        chk("t2_underrun", underrun, 0);

        // Two-cycle source gap after beat 1.
        do_reset("t3_reset");
        gap_at = 1;
        enable = 1'b1;
        src_en = 1'b1;
        wait_log(8, 300, "t3_beats");
        if (acc_log.size() >= 4) begin
            chk("t3_gap", acc_log[2].cyc - acc_log[1].cyc, 3);
            chk("t3_tlast3", acc_log[3].last, 1);
        end
        chk("t3_underrun", underrun, 1);
        wait_log(16, 300, "t3_more");
        chk("t3_underrun_sticky", underrun, 1);

        // Enable dropped during line 0: frame still completes, then IDLE.
        do_reset("t4_reset");
        enable = 1'b1;
        src_en = 1'b1;
        wait_log(2, 100, "t4_start");
        enable = 1'b0;
        wait_log(8, 300, "t4_frame");
        repeat (VB + 4) @(posedge clk);
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            chk("t4_idle_sready", sready, 0);
            chk("t4_idle_tvalid", tvalid, 0);
        end
        chk("t4_beat_count", acc_log.size(), 8);
        chk("t4_fd_count", fd_cyc.size(), 1);

        // Asynchronous reset while beat 2 is on the output.
        do_reset("t5_reset");
        enable = 1'b1;
        src_en = 1'b1;
        wait_visible(2, "t5_beat2");
        rst_n = 1'b0;
        #1;
        check_zero("t5_async");
        finish_reset();
        enable = 1'b1;
        src_en = 1'b1;
        wait_log(8, 300, "t5_beats");
        if (acc_log.size() >= 4) begin
            chk("t5_tuser0", acc_log[0].user, 1);
            chk("t5_tlast3", acc_log[3].last, 1);
        end

        // Random back-pressure over four frames.
        do_reset("t6_reset");
        enable = 1'b1;
        src_en = 1'b1;
        for (int c = 0; c < 3000 && acc_log.size() < 4 * FB; c++) begin
            @(posedge clk);
            #1;
            tready = ($urandom_range(0, 3) != 0);
        end
        tready = 1'b1;
        chk("t6_beats", acc_log.size(), 4 * FB);
        nl = 0;
        for (int i = 0; i < acc_log.size() && i < 4 * FB; i++) if (acc_log[i].last) nl++;
        chk("t6_tlast_count", nl, 4 * IH);
        repeat (3) @(posedge clk);
        chk("t6_fd_count", fd_cyc.size(), 4);
        chk("t6_underrun", underrun, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
